// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with valid/ready handshake, 2-entry skid buffer,
// flush with NOP injection and a saturating stall counter.
module pipe_skid_stage #(
    parameter int unsigned DATA_W  = 64,
    parameter logic [63:0] NOP_VAL = 64'h13,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_VAL);

    state_e             state_q;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_q;

    logic push;
    logic pop;

    // Handshake transfers seen at the coming edge.
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Occupancy FSM with main/skid storage; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            main_q      <= NOP_DATA;
            skid_q      <= NOP_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            main_q      <= NOP_DATA;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_q     <= S_ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        state_q    <= S_FULL;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= S_EMPTY;
                        main_q      <= NOP_DATA;
                        out_valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_q    <= S_ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    main_q      <= NOP_DATA;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    // Occupancy encoding 3 must never be reached.
    a_occ_legal: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy != 2'd3);

    // Held output must not change while downstream stalls.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and random checks of pipe_skid_stage against hand-computed values
// and a queue model.
module tb_pipe_skid_stage;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;
    localparam logic [63:0] NOP    = 64'h13;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests;
    int n_fail;

    pipe_skid_stage #(
        .DATA_W  (DATA_W),
        .NOP_VAL (64'h13),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [63:0] d,
                               input logic [1:0] occ, input logic rdy);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".data"},  64'(out_data),  d);
        check({tag, ".occ"},   64'(occupancy), 64'(occ));
        check({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    endtask

    logic [DATA_W-1:0] mq[$];
    int unsigned       ms;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_state("reset", 1'b0, NOP, 2'd0, 1'b1);
        check("reset.stall", 64'(stall_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // 1. pass-through
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hA1;
        step();
        check_state("pass.a1", 1'b1, 64'hA1, 2'd1, 1'b1);
        in_data = 16'hA2;
        step();
        check_state("pass.a2", 1'b1, 64'hA2, 2'd1, 1'b1);
        in_data = 16'hA3;
        step();
        check_state("pass.a3", 1'b1, 64'hA3, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        check_state("pass.drain", 1'b0, NOP, 2'd0, 1'b1);
        check("pass.stall", 64'(stall_cnt), 64'd0);

        // 2. stall fill and release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hB1;
        step();
        check_state("fill.b1", 1'b1, 64'hB1, 2'd1, 1'b1);
        in_data = 16'hB2;
        step();
        check_state("fill.b2", 1'b1, 64'hB1, 2'd2, 1'b0);
        in_valid = 1'b0;
        step();
        check_state("fill.hold", 1'b1, 64'hB1, 2'd2, 1'b0);
        check("fill.stall", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        step();
        check_state("fill.pop1", 1'b1, 64'hB2, 2'd1, 1'b1);
        step();
        check_state("fill.pop2", 1'b0, NOP, 2'd0, 1'b1);
        check("fill.stall2", 64'(stall_cnt), 64'd2);

        // 3. flush while full with a live push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC1;
        step();
        in_data = 16'hC2;
        step();
        check_state("flush.full", 1'b1, 64'hC1, 2'd2, 1'b0);
        flush   = 1'b1;
        in_data = 16'hC3;
        step();
        check_state("flush.kill", 1'b0, NOP, 2'd0, 1'b1);
        check("flush.stall", 64'(stall_cnt), 64'd4);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check_state("flush.after", 1'b0, NOP, 2'd0, 1'b1);

        // 4. simultaneous push and pop in ONE
        in_valid = 1'b1;
        in_data  = 16'hD1;
        step();
        check_state("pp.d1", 1'b1, 64'hD1, 2'd1, 1'b1);
        in_data   = 16'hD2;
        out_ready = 1'b1;
        step();
        check_state("pp.d2", 1'b1, 64'hD2, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        check_state("pp.drain", 1'b0, NOP, 2'd0, 1'b1);
        check("pp.stall", 64'(stall_cnt), 64'd4);

        // 5. counter saturation, flush persistence, async reset mid-cycle
        rst_n = 1'b0;
        #1;
        check("sat.rst", 64'(stall_cnt), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hE1;
        step();
        in_valid = 1'b0;
        check("sat.start", 64'(stall_cnt), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("sat.cnt%0d", i), 64'(stall_cnt), 64'((i > 7) ? 7 : i));
        end
        check("sat.data", 64'(out_data), 64'hE1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sat.flush", 64'(stall_cnt), 64'd7);
        check("sat.flushv", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_data  = 16'hF1;
        step();
        in_valid = 1'b0;
        check("arst.pre", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_state("arst", 1'b0, NOP, 2'd0, 1'b1);
        check("arst.stall", 64'(stall_cnt), 64'd0);
        #1 rst_n = 1'b1;
        step();

        // 6. random traffic against a queue model
        mq.delete();
        ms = 0;
        for (int c = 0; c < 10000; c++) begin
            logic pu;
            logic po;
            flush     = ($urandom_range(99) < 3);
            in_valid  = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 55);
            in_data   = DATA_W'($urandom);
            pu = in_valid && (mq.size() != 2);
            po = (mq.size() != 0) && out_ready;
            if ((mq.size() != 0) && !out_ready && (ms != 7)) ms++;
            if (flush) begin
                mq.delete();
            end else begin
                if (po) void'(mq.pop_front());
                if (pu) mq.push_back(in_data);
            end
            step();
            check("rnd.valid", 64'(out_valid), 64'(mq.size() != 0));
            check("rnd.data",  64'(out_data), (mq.size() != 0) ? 64'(mq[0]) : NOP);
            check("rnd.occ",   64'(occupancy), 64'(mq.size()));
            check("rnd.ready", 64'(in_ready), 64'(mq.size() != 2));
            check("rnd.stall", 64'(stall_cnt), 64'(ms));
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
